// File: rtl/separator_ejector_pkg.sv
// Shared types for the separator ejector.
//   bin_t      : 2-bit classification code from the light separator
//   BIN_*      : bin codes (PASS = no eject, A/B/C = valve 0/1/2)
//   entry_t    : pending-eject record {bin, target position} at default width
//   DEF_*      : default position counter and pulse field widths
package separator_pkg;

    localparam int DEF_POS_W   = 16;
    localparam int DEF_PULSE_W = 8;

    typedef logic [1:0] bin_t;

    localparam bin_t BIN_PASS = 2'd0;
    localparam bin_t BIN_A    = 2'd1;
    localparam bin_t BIN_B    = 2'd2;
    localparam bin_t BIN_C    = 2'd3;

    typedef struct packed {
        bin_t                 bin;
        logic [DEF_POS_W-1:0] target;
    } entry_t;

endpackage

// File: rtl/separator_ejector_if.sv
// Classification-result handshake between the light separator and the ejector.
//   item_valid : result present (driven by separator)
//   item_bin   : classification code (driven by separator)
//   item_ready : ejector takes the result this cycle (driven by ejector)
// Handshake: a result transfers on a rising clk edge where item_valid and
// item_ready are both high; item_ready never depends on item_valid.
interface separator_ejector_if;
    import separator_pkg::*;

    logic item_valid;
    logic item_ready;
    bin_t item_bin;

    modport master (output item_valid, output item_bin, input item_ready);
    modport slave  (input item_valid, input item_bin, output item_ready);

endinterface

// File: rtl/separator_ejector_valve_pulse.sv
// One air-valve pulse generator.
//   clk, rst  : clock, synchronous active-high reset
//   trig      : load the counter this cycle (retrigger reloads, no gap)
//   pulse_len : open time in clk cycles; 0 behaves as 1
//   valve     : high while the counter is non-zero
module valve_pulse #(
    parameter int PULSE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig,
    input  logic [PULSE_W-1:0] pulse_len,
    output logic               valve
);

    logic [PULSE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (trig) begin
            cnt <= (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
        end else if (cnt != '0) begin
            cnt <= cnt - PULSE_W'(1);
        end
    end

    // Gated by rst so the valve drops in the very cycle reset is applied.
    assign valve = (cnt != '0) && !rst;

endmodule

// File: rtl/separator_ejector.sv
// Conveyor separator ejector: queues classified items with the conveyor
// position at which they reach the valves, and fires the matching air valve
// when the encoder position gets there.
//   clk, rst   : clock, synchronous active-high reset
//   item       : classification handshake (slave side)
//   enc_tick   : one-cycle encoder pulse, advances the position counter
//   cfg_delay  : ticks from classification to valve (< 2^(POS_W-1))
//   cfg_pulse  : valve open time in clk cycles (0 acts as 1)
//   valve      : air-valve drives, bit n fires for bin n+1
//   pending    : number of queued ejects
//   late_err   : sticky, an item's position went by before it could fire
module separator_ejector
    import separator_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int POS_W   = DEF_POS_W,
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    separator_ejector_if.slave       item,
    input  logic                     enc_tick,
    input  logic [POS_W-1:0]         cfg_delay,
    input  logic [PULSE_W-1:0]       cfg_pulse,
    output logic [2:0]               valve,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     late_err
);

    localparam int AW = $clog2(DEPTH);

    // Same layout as entry_t, but sized by this instance's POS_W.
    typedef struct packed {
        bin_t             bin;
        logic [POS_W-1:0] target;
    } slot_t;

    slot_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_next;
    logic [POS_W-1:0] head_diff;
    slot_t           head;
    logic            full;
    logic            push;
    logic            hit;
    logic            late;
    logic            pop;
    logic [2:0]      trig;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign item.item_ready = !full && !rst;

    // Target uses the position after any same-cycle tick.
    assign pos_next = pos + POS_W'(enc_tick);
    assign push     = item.item_valid && item.item_ready && (item.item_bin != BIN_PASS);

    // Modular distance of the head target behind pos: 0 = due now,
    // lower half = already passed, upper half = still ahead.
    assign head      = mem[rd_ptr];
    assign head_diff = pos - head.target;
    assign hit       = (count != '0) && (head_diff == '0);
    assign late      = (count != '0) && (head_diff != '0) && !head_diff[POS_W-1];
    assign pop       = hit || late;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{bin: item.item_bin, target: pos_next + cfg_delay};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            late_err <= 1'b0;
        end else begin
            pos <= pos_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (late) late_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_valve
        assign trig[i] = hit && (head.bin == bin_t'(i + 1));

        valve_pulse #(.PULSE_W(PULSE_W)) u_valve (
            .clk       (clk),
            .rst       (rst),
            .trig      (trig[i]),
            .pulse_len (cfg_pulse),
            .valve     (valve[i])
        );
    end

    assign pending = count;

endmodule

// File: tb/tb_separator_ejector.sv
module tb_separator_ejector;
    import separator_pkg::*;

    logic        clk;
    logic        rst;
    logic        enc_tick;
    logic [15:0] cfg_delay;
    logic [7:0]  cfg_pulse;
    logic [2:0]  valve;
    logic [3:0]  pending;
    logic        late_err;

    int checks;
    int errors;

    separator_ejector_if item_if ();

    separator_ejector #(.DEPTH(8), .POS_W(16), .PULSE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .item      (item_if),
        .enc_tick  (enc_tick),
        .cfg_delay (cfg_delay),
        .cfg_pulse (cfg_pulse),
        .valve     (valve),
        .pending   (pending),
        .late_err  (late_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        enc_tick = 1'b1;
        repeat (n) step();
        enc_tick = 1'b0;
    endtask

    task automatic push_item(input bin_t b);
        item_if.item_valid = 1'b1;
        item_if.item_bin   = b;
        step();
        item_if.item_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        item_if.item_valid = 1'b0;
        item_if.item_bin   = BIN_PASS;
        enc_tick = 1'b0;
        step();
        step();
        checks++;
        if (item_if.item_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready got %0b want 0", item_if.item_ready);
        end
        checks++;
        if (pending !== 4'd0) begin
            errors++; $display("FAIL rst_pending got %0d want 0", pending);
        end
        checks++;
        if (valve !== 3'b000) begin
            errors++; $display("FAIL rst_valve got %b want 000", valve);
        end
        checks++;
        if (late_err !== 1'b0) begin
            errors++; $display("FAIL rst_late got %0b want 0", late_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (item_if.item_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_rst got %0b want 1", item_if.item_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_zero_delay();
        do_reset();
        cfg_delay = 16'd0;
        cfg_pulse = 8'd0;
        push_item(BIN_C);
        checks++;
        if (pending !== 4'd1 || valve !== 3'b000) begin
            errors++; $display("FAIL zd_queued got p=%0d v=%b want p=1 v=000", pending, valve);
        end
        step();
        checks++;
        if (pending !== 4'd0 || valve !== 3'b100) begin
            errors++; $display("FAIL zd_fire got p=%0d v=%b want p=0 v=100", pending, valve);
        end
        step();
        checks++;
        if (valve !== 3'b000) begin
            errors++; $display("FAIL zd_pulse1 got %b want 000", valve);
        end
        push_item(BIN_PASS);
        step();
        step();
        checks++;
        if (pending !== 4'd0 || valve !== 3'b000) begin
            errors++; $display("FAIL pass_bin got p=%0d v=%b want p=0 v=000", pending, valve);
        end
    endtask

    task automatic test_basic_fire();
        logic [2:0] exp_v [4] = '{3'b010, 3'b010, 3'b010, 3'b000};
        do_reset();
        cfg_delay = 16'd5;
        cfg_pulse = 8'd3;
        tick_n(10);
        push_item(BIN_B);
        checks++;
        if (pending !== 4'd1) begin
            errors++; $display("FAIL basic_push got %0d want 1", pending);
        end
        tick_n(5);
        checks++;
        if (valve !== 3'b000 || pending !== 4'd1) begin
            errors++; $display("FAIL basic_at15 got v=%b p=%0d want v=000 p=1", valve, pending);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (valve !== exp_v[i]) begin
                errors++; $display("FAIL basic_pulse[%0d] got %b want %b", i, valve, exp_v[i]);
            end
        end
        checks++;
        if (pending !== 4'd0 || late_err !== 1'b0) begin
            errors++; $display("FAIL basic_done got p=%0d late=%0b want p=0 late=0", pending, late_err);
        end
    endtask

    task automatic test_same_target();
        logic [2:0] exp_v [6] = '{3'b001, 3'b101, 3'b101, 3'b101, 3'b100, 3'b000};
        do_reset();
        cfg_delay = 16'd3;
        cfg_pulse = 8'd4;
        push_item(BIN_A);
        push_item(BIN_C);
        tick_n(3);
        checks++;
        if (valve !== 3'b000 || pending !== 4'd2) begin
            errors++; $display("FAIL same_pre got v=%b p=%0d want v=000 p=2", valve, pending);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (valve !== exp_v[i]) begin
                errors++; $display("FAIL same_pulse[%0d] got %b want %b", i, valve, exp_v[i]);
            end
        end
        checks++;
        if (late_err !== 1'b0 || pending !== 4'd0) begin
            errors++; $display("FAIL same_done got late=%0b p=%0d want late=0 p=0", late_err, pending);
        end
    endtask

    task automatic test_late();
        do_reset();
        cfg_delay = 16'd2;
        cfg_pulse = 8'd3;
        push_item(BIN_A);
        push_item(BIN_B);
        tick_n(3);
        checks++;
        if (valve !== 3'b001 || pending !== 4'd1 || late_err !== 1'b0) begin
            errors++; $display("FAIL late_first got v=%b p=%0d late=%0b want v=001 p=1 late=0", valve, pending, late_err);
        end
        step();
        checks++;
        if (pending !== 4'd0 || late_err !== 1'b1) begin
            errors++; $display("FAIL late_drop got p=%0d late=%0b want p=0 late=1", pending, late_err);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (valve[1] !== 1'b0 || late_err !== 1'b1) begin
                errors++; $display("FAIL late_hold[%0d] got v1=%0b late=%0b want v1=0 late=1", i, valve[1], late_err);
            end
        end
    endtask

    task automatic test_retrigger();
        int bad;
        do_reset();
        cfg_delay = 16'd4;
        cfg_pulse = 8'd200;
        push_item(BIN_A);
        tick_n(2);
        push_item(BIN_A);
        tick_n(2);
        checks++;
        if (valve !== 3'b000 || pending !== 4'd2) begin
            errors++; $display("FAIL retrig_pre got v=%b p=%0d want v=000 p=2", valve, pending);
        end
        bad = 0;
        // two ticks carry pos 4 -> 6 while the first pulse runs
        enc_tick = 1'b1;
        step();
        if (valve !== 3'b001) bad++;
        step();
        if (valve !== 3'b001) bad++;
        enc_tick = 1'b0;
        step();  // second trigger loads the counter on this edge
        if (valve !== 3'b001) bad++;
        for (int i = 0; i < 199; i++) begin
            step();
            if (valve !== 3'b001) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL retrig_cont got %0d low samples want 0", bad);
        end
        step();
        checks++;
        if (valve !== 3'b000) begin
            errors++; $display("FAIL retrig_fall got %b want 000", valve);
        end
    endtask

    task automatic test_full();
        do_reset();
        cfg_delay = 16'd100;
        cfg_pulse = 8'd2;
        item_if.item_valid = 1'b1;
        item_if.item_bin   = BIN_A;
        repeat (8) step();
        checks++;
        if (pending !== 4'd8 || item_if.item_ready !== 1'b0) begin
            errors++; $display("FAIL full_8 got p=%0d rdy=%0b want p=8 rdy=0", pending, item_if.item_ready);
        end
        item_if.item_bin = BIN_C;
        tick_n(100);
        checks++;
        if (pending !== 4'd8 || item_if.item_ready !== 1'b0) begin
            errors++; $display("FAIL full_held got p=%0d rdy=%0b want p=8 rdy=0", pending, item_if.item_ready);
        end
        step();
        checks++;
        if (pending !== 4'd7 || item_if.item_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop got p=%0d rdy=%0b want p=7 rdy=1", pending, item_if.item_ready);
        end
        step();
        item_if.item_valid = 1'b0;
        checks++;
        if (pending !== 4'd7) begin
            errors++; $display("FAIL push_pop got p=%0d want 7", pending);
        end
        repeat (6) step();
        checks++;
        if (pending !== 4'd1 || valve !== 3'b001 || late_err !== 1'b0) begin
            errors++; $display("FAIL full_drain got p=%0d v=%b late=%0b want p=1 v=001 late=0", pending, valve, late_err);
        end
        do_reset();  // mid-pulse with an item queued
    endtask

    task automatic test_wrap();
        do_reset();
        cfg_delay = 16'd6;
        cfg_pulse = 8'd2;
        tick_n(65533);
        push_item(BIN_A);
        tick_n(5);
        checks++;
        if (valve !== 3'b000 || pending !== 4'd1 || late_err !== 1'b0) begin
            errors++; $display("FAIL wrap_wait got v=%b p=%0d late=%0b want v=000 p=1 late=0", valve, pending, late_err);
        end
        tick_n(1);
        step();
        checks++;
        if (valve !== 3'b001 || pending !== 4'd0 || late_err !== 1'b0) begin
            errors++; $display("FAIL wrap_fire got v=%b p=%0d late=%0b want v=001 p=0 late=0", valve, pending, late_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        enc_tick = 1'b0;
        cfg_delay = 16'd0;
        cfg_pulse = 8'd1;
        item_if.item_valid = 1'b0;
        item_if.item_bin   = BIN_PASS;
        test_reset();
        test_zero_delay();
        test_basic_fire();
        test_same_target();
        test_late();
        test_retrigger();
        test_full();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
